// File: rtl/tlc_pkg.sv
// Shared definitions for the highway/farm-road traffic light controller:
// lamp encoding, controller states and default tuning parameters.
package tlc_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned WDOG_MAX_DEF    = 64;

  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    FG    = 3'd2,
    FY    = 3'd3,
    FAULT = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0] hwy;
    logic [1:0] farm;
  } lamps_t;

  // Lamp pair shown while the controller sits in a given state.
  function automatic lamps_t lamps_of(state_e s);
    lamps_t l;
    unique case (s)
      HG:      l = '{hwy: GREEN,  farm: RED};
      HY:      l = '{hwy: YELLOW, farm: RED};
      FG:      l = '{hwy: RED,    farm: GREEN};
      FY:      l = '{hwy: RED,    farm: YELLOW};
      default: l = '{hwy: YELLOW, farm: YELLOW};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level input.
module sync_2ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tlc_fsm.sv
// Traffic light controller: sequences highway/farm lamps from the car sensor,
// issues timer start pulses and traps into FAULT when a timer goes silent.
module tlc_fsm
  import tlc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned WDOG_MAX    = WDOG_MAX_DEF
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       car,
  input  logic       TL_out,
  input  logic       TS_out,
  output logic       TL_start,
  output logic       TS_start,
  output logic [1:0] hwy_light,
  output logic [1:0] farm_light,
  output logic       fault
);

  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_MAX);

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              elapsed_q, elapsed_d;
  logic              pend_q, pend_d;
  logic              blank_q, blank_d;
  logic              tl_start_q, tl_start_d;
  logic              ts_start_q, ts_start_d;
  logic              fault_q, fault_d;
  lamps_t            lamps_q, lamps_d;

  logic car_s;
  logic timer_ok, tl_exp, ts_exp, expiry, waiting, wdog_expired;

  sync_2ff #(.SYNC_STAGES(SYNC_STAGES)) u_car_sync (
    .clk  (clk),
    .arst (arst),
    .d_i  (car),
    .q_o  (car_s)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= HG;
      wdog_q     <= '0;
      elapsed_q  <= 1'b0;
      pend_q     <= 1'b1;
      blank_q    <= 1'b0;
      tl_start_q <= 1'b0;
      ts_start_q <= 1'b0;
      fault_q    <= 1'b0;
      lamps_q    <= lamps_of(HG);
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      elapsed_q  <= elapsed_d;
      pend_q     <= pend_d;
      blank_q    <= blank_d;
      tl_start_q <= tl_start_d;
      ts_start_q <= ts_start_d;
      fault_q    <= fault_d;
      lamps_q    <= lamps_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    elapsed_d  = elapsed_q;
    pend_d     = 1'b0;
    tl_start_d = pend_q && (state_q == HG || state_q == FG);
    ts_start_d = pend_q && (state_q == HY || state_q == FY);
    blank_d    = tl_start_q | ts_start_q;

    // Expiries are stale from entry until the cycle after the start pulse.
    timer_ok     = !(pend_q | tl_start_q | ts_start_q | blank_q);
    tl_exp       = TL_out & timer_ok;
    ts_exp       = TS_out & timer_ok;
    expiry       = (state_q == HG || state_q == FG) ? tl_exp : ts_exp;
    waiting      = (state_q != FAULT) && !(state_q == HG && elapsed_q);
    wdog_expired = waiting && (wdog_q == WDOG_LIMIT);

    if (waiting && !pend_q && (wdog_q != WDOG_LIMIT)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end

    unique case (state_q)
      HG: begin
        if (tl_exp) elapsed_d = 1'b1;
        if ((elapsed_q || tl_exp) && car_s) state_d = HY;
      end
      HY:      if (ts_exp) state_d = FG;
      FG:      if (tl_exp || !car_s) state_d = FY;
      FY:      if (ts_exp) state_d = HG;
      default: state_d = FAULT;
    endcase

    if (wdog_expired && !expiry && (state_d == state_q)) begin
      state_d = FAULT;
    end

    if (state_d != state_q) begin
      wdog_d    = '0;
      elapsed_d = 1'b0;
      pend_d    = (state_d != FAULT);
    end

    lamps_d = lamps_of(state_d);
    fault_d = (state_d == FAULT);
  end

  assign TL_start   = tl_start_q;
  assign TS_start   = ts_start_q;
  assign hwy_light  = lamps_q.hwy;
  assign farm_light = lamps_q.farm;
  assign fault      = fault_q;

endmodule

// File: tb/tb_tlc_fsm.sv
// Self-checking bench for tlc_fsm with behavioural long/short timers and a
// lamp-sequence scoreboard.
module tb_tlc_fsm;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned WDOG   = 64;
  localparam int unsigned TL_PER = 16;
  localparam int unsigned TS_PER = 5;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;

  typedef struct packed {
    logic [1:0] hwy;
    logic [1:0] farm;
    logic       flt;
  } obs_t;

  localparam obs_t O_HG = {G, R, 1'b0};
  localparam obs_t O_HY = {Y, R, 1'b0};
  localparam obs_t O_FG = {R, G, 1'b0};
  localparam obs_t O_FY = {R, Y, 1'b0};
  localparam obs_t O_FT = {Y, Y, 1'b1};

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       car = 1'b0;
  logic       tl_force = 1'b0;
  logic       ts_sup = 1'b0;
  logic       TL_out, TS_out, TL_start, TS_start, fault;
  logic [1:0] hwy_light, farm_light;

  int unsigned tl_cnt, ts_cnt;
  int n_tests = 0;
  int n_fail = 0;
  int tl_total = 0;
  int ts_total = 0;
  int starts = 0;
  obs_t exp_q[$];
  obs_t prev_o = O_HG;
  obs_t cur_o, exp_o;

  always #5 clk = ~clk;

  tlc_fsm #(.SYNC_STAGES(SYNC), .WDOG_MAX(WDOG)) dut (
    .clk        (clk),
    .arst       (arst),
    .car        (car),
    .TL_out     (TL_out),
    .TS_out     (TS_out),
    .TL_start   (TL_start),
    .TS_start   (TS_start),
    .hwy_light  (hwy_light),
    .farm_light (farm_light),
    .fault      (fault)
  );

  // Behavioural timers: cleared by their start pulse, one-cycle expiry per wrap.
  assign TL_out = (tl_cnt == TL_PER - 1) || tl_force;
  assign TS_out = (ts_cnt == TS_PER - 1) && !ts_sup;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      tl_cnt <= 0;
      ts_cnt <= 0;
    end else begin
      tl_cnt <= (TL_start || tl_cnt == TL_PER - 1) ? 0 : tl_cnt + 1;
      ts_cnt <= (TS_start || ts_cnt == TS_PER - 1) ? 0 : ts_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t cur_obs();
    return {hwy_light, farm_light, fault};
  endfunction

  // Scoreboard monitor: lamp changes pop the expected queue; one start per state.
  always @(negedge clk) begin
    cur_o = cur_obs();
    if (arst) begin
      prev_o = O_HG;
      starts = 0;
    end else begin
      if (TL_start) begin
        tl_total++;
        starts++;
        check("tl_start_on_green", 32'(hwy_light == G || farm_light == G), 32'd1);
      end
      if (TS_start) begin
        ts_total++;
        starts++;
        check("ts_start_on_yellow", 32'(hwy_light == Y || farm_light == Y), 32'd1);
      end
      if (cur_o != prev_o) begin
        if (!prev_o.flt) check("starts_per_state", 32'(starts), 32'd1);
        starts = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_change", 32'(cur_o), 32'(prev_o));
        end else begin
          exp_o = exp_q.pop_front();
          check("lamp_seq", 32'(cur_o), 32'(exp_o));
        end
        prev_o = cur_o;
      end
    end
  end

  task automatic wait_obs(input string tag, input obs_t want, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(negedge clk);
      n++;
      if (cur_obs() == want) break;
    end
    check(tag, 32'(cur_obs()), 32'(want));
  endtask

  initial begin
    int n;
    #1 arst = 1'b1;

    // Reset values, first start pulse, idle highway with no car.
    repeat (3) @(negedge clk);
    check("rst_obs", 32'(cur_obs()), 32'(O_HG));
    check("rst_tl_start", 32'(TL_start), 32'd0);
    check("rst_ts_start", 32'(TS_start), 32'd0);
    #1 arst = 1'b0;
    @(posedge clk); #1;
    check("tl_start_c1", 32'(TL_start), 32'd1);
    @(posedge clk); #1;
    check("tl_start_c2", 32'(TL_start), 32'd0);
    repeat (200) @(negedge clk);
    check("idle_obs", 32'(cur_obs()), 32'(O_HG));
    check("idle_tl_starts", 32'(tl_total), 32'd1);
    check("idle_ts_starts", 32'(ts_total), 32'd0);

    // Late car after TL expired, then farm road empties early in FG.
    exp_q.push_back(O_HY);
    exp_q.push_back(O_FG);
    exp_q.push_back(O_FY);
    exp_q.push_back(O_HG);
    car = 1'b1;
    wait_obs("late_car_hy", O_HY, SYNC + 1, n);
    check("late_car_latency", 32'(n), 32'(SYNC + 1));
    wait_obs("b_fg", O_FG, 20, n);
    check("b_hy_dwell", 32'(n), 32'd7);
    repeat (4) @(negedge clk);
    car = 1'b0;
    wait_obs("fg_drop_fy", O_FY, SYNC + 1, n);
    check("fg_drop_latency", 32'(n), 32'(SYNC + 1));
    wait_obs("b_hg", O_HG, 20, n);
    check("b_fy_dwell", 32'(n), 32'd7);

    // Fresh reset, car from cycle 5: full G/R, Y/R, R/G, R/Y, G/R sequence.
    @(negedge clk); #1 arst = 1'b1;
    @(negedge clk);
    check("rst2_obs", 32'(cur_obs()), 32'(O_HG));
    #1 arst = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back(O_HY);
    exp_q.push_back(O_FG);
    exp_q.push_back(O_FY);
    exp_q.push_back(O_HG);
    car = 1'b1;
    wait_obs("c_hy", O_HY, 20, n);
    check("c_hy_latency", 32'(n + 5), 32'd18);
    wait_obs("c_fg", O_FG, 20, n);
    check("c_hy_dwell", 32'(n), 32'd7);
    wait_obs("c_fy", O_FY, 30, n);
    check("c_fg_dwell", 32'(n), 32'd18);
    wait_obs("c_hg", O_HG, 20, n);
    check("c_fy_dwell", 32'(n), 32'd7);
    car = 1'b0;

    // Silent short timer in HY: watchdog fault, sticky until reset.
    repeat (3) @(negedge clk);
    exp_q.push_back(O_HY);
    exp_q.push_back(O_FT);
    ts_sup = 1'b1;
    car = 1'b1;
    wait_obs("d_hy", O_HY, 40, n);
    n = 0;
    while (!TS_start && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("d_ts_start", 32'(TS_start), 32'd1);
    n = 0;
    while (!fault && n < int'(WDOG) + 10) begin
      @(negedge clk);
      n++;
    end
    check("fault_latency", 32'(n), 32'(WDOG + 1));
    check("fault_obs", 32'(cur_obs()), 32'(O_FT));
    ts_sup = 1'b0;
    repeat (30) @(negedge clk);
    check("fault_sticky", 32'(cur_obs()), 32'(O_FT));
    #1 arst = 1'b1;
    #1;
    check("arst_clears_fault", 32'(cur_obs()), 32'(O_HG));

    // Forced TL_out in the start cycle and the next is ignored; reset mid-HY.
    exp_q.push_back(O_HY);
    @(negedge clk); #1 arst = 1'b0;
    @(posedge clk); #1 tl_force = 1'b1;
    check("e_tl_start", 32'(TL_start), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1 tl_force = 1'b0;
    repeat (3) @(negedge clk);
    check("force_ignored", 32'(cur_obs()), 32'(O_HG));
    wait_obs("e_hy", O_HY, 20, n);
    check("e_hy_latency", 32'(n + 5), 32'd18);
    @(posedge clk); #1;
    check("e_hy_ts_start", 32'(TS_start), 32'd1);
    arst = 1'b1;
    #1;
    check("e_rst_obs", 32'(cur_obs()), 32'(O_HG));
    check("e_rst_ts_start", 32'(TS_start), 32'd0);
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
